multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_if.sv | 45 ++++
 rtl/multicycle_control.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle for the multicycle control unit.
//   instr_valid, opcode     : fetched instruction handshake (datapath -> control)
//   zero, mem_ready         : ALU zero flag and data-memory completion
//   fetch_req .. mem_write  : single-bit datapath strobes (control -> datapath)
//   pc_src, alu_op          : PC source select and ALU function select
//   state                   : current controller state encoding
//   illegal_op, mem_timeout : sticky error flags
// master = controller side, slave = datapath side.
interface multicycle_control_if #(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 2
);
  logic                instr_valid;
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;
  logic                fetch_req;
  logic                ir_write;
  logic                pc_write;
  logic                alu_src;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                reg_write;
  logic                mem_read;
  logic                mem_write;
  logic [1:0]          pc_src;
  logic [ALU_OP_W-1:0] alu_op;
  logic [2:0]          state;
  logic                illegal_op;
  logic                mem_timeout;

  modport master (
    input  instr_valid, opcode, zero, mem_ready,
    output fetch_req, ir_write, pc_write, alu_src, reg_dst, mem_to_reg,
           reg_write, mem_read, mem_write, pc_src, alu_op, state,
           illegal_op, mem_timeout
  );

  modport slave (
    output instr_valid, opcode, zero, mem_ready,
    input  fetch_req, ir_write, pc_write, alu_src, reg_dst, mem_to_reg,
           reg_write, mem_read, mem_write, pc_src, alu_op, state,
           illegal_op, mem_timeout
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle processor control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : multicycle_control_if.master (instruction handshake, flags in,
//           datapath strobes, state and sticky error flags out)
// Parameters: OPCODE_W (opcode width), ALU_OP_W (alu_op width),
//             MEM_TIMEOUT (max MEM wait cycles before error).
module multicycle_control #(
  parameter int OPCODE_W    = 4,
  parameter int ALU_OP_W    = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_control_if.master          bus
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    ERROR  = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_LW, C_SW, C_DP, C_BEQ, C_BNE, C_J, C_ILL
  } op_class_e;

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                illegal_q, illegal_d;
  logic                timeout_q, timeout_d;
  op_class_e           cls;

  // Any set bit above bit 3 makes the opcode illegal regardless of low nibble.
  always_comb begin
    cls = C_ILL;
    if ((ir_q >> 4) == '0) begin
      case (ir_q[3:0])
        4'd0:                         cls = C_LW;
        4'd1:                         cls = C_SW;
        4'd2, 4'd3, 4'd4, 4'd5,
        4'd6, 4'd7, 4'd8, 4'd9:       cls = C_DP;
        4'd11:                        cls = C_BEQ;
        4'd12:                        cls = C_BNE;
        4'd13:                        cls = C_J;
        default:                      cls = C_ILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      FETCH: begin
        if (bus.instr_valid) begin
          ir_d    = bus.opcode;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (cls == C_ILL) begin
          illegal_d = 1'b1;
          state_d   = ERROR;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (cls)
          C_LW, C_SW: begin
            cnt_d   = '0;
            state_d = MEM;
          end
          C_DP:    state_d = WB;
          C_ILL:   state_d = ERROR;
          default: state_d = FETCH;
        endcase
      end
      MEM: begin
        // cnt_q counts completed wait cycles, so the MEM_TIMEOUT-th MEM cycle
        // sees MEM_TIMEOUT-1; mem_ready in that cycle still completes.
        if (bus.mem_ready) begin
          state_d = (cls == C_LW) ? WB : FETCH;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WB:      state_d = FETCH;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
  end

  always_comb begin
    bus.fetch_req   = 1'b0;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.alu_src     = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.reg_write   = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.pc_src      = 2'b00;
    bus.alu_op      = '0;
    bus.state       = state_q;
    bus.illegal_op  = illegal_q;
    bus.mem_timeout = timeout_q;
    if (reset) begin
      // Idle FETCH view while reset is held, independent of registered state.
      bus.fetch_req   = 1'b1;
      bus.state       = FETCH;
      bus.illegal_op  = 1'b0;
      bus.mem_timeout = 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          bus.fetch_req = 1'b1;
          if (bus.instr_valid) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
          end
        end
        EXEC: begin
          case (cls)
            C_LW, C_SW: begin
              bus.alu_src = 1'b1;
            end
            C_DP: begin
              bus.alu_op = ALU_OP_W'(2'b10);
            end
            C_BEQ, C_BNE: begin
              bus.alu_op = ALU_OP_W'(2'b01);
              if ((cls == C_BEQ && bus.zero) || (cls == C_BNE && !bus.zero)) begin
                bus.pc_write = 1'b1;
                bus.pc_src   = 2'b01;
              end
            end
            C_J: begin
              bus.pc_write = 1'b1;
              bus.pc_src   = 2'b10;
            end
            default: ;
          endcase
        end
        MEM: begin
          bus.alu_src   = 1'b1;
          bus.mem_read  = (cls == C_LW);
          bus.mem_write = (cls == C_SW);
        end
        WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = (cls == C_LW);
          bus.reg_dst    = (cls == C_DP);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  int unsigned total = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  multicycle_control_if #(.OPCODE_W(4), .ALU_OP_W(2)) bus ();

  multicycle_control #(.OPCODE_W(4), .ALU_OP_W(2), .MEM_TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [3:0] op, input logic z, input logic mr);
    bus.instr_valid = iv;
    bus.opcode      = op;
    bus.zero        = z;
    bus.mem_ready   = mr;
    #1;
  endtask

  // In FETCH: present an instruction, check acceptance strobes, advance to DECODE.
  task automatic accept(input logic [3:0] op);
    drive(1'b1, op, 1'b0, 1'b0);
    chk("fetch_state", int'(bus.state), 0);
    chk("fetch_ir_write", int'(bus.ir_write), 1);
    chk("fetch_pc_write", int'(bus.pc_write), 1);
    chk("fetch_pc_src", int'(bus.pc_src), 0);
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    chk("decode_state", int'(bus.state), 1);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 4'd0, 1'b0, 1'b0);
    chk("rst_fetch_req", int'(bus.fetch_req), 1);
    chk("rst_ir_write", int'(bus.ir_write), 0);
    chk("rst_state", int'(bus.state), 0);
    chk("rst_flags", int'({bus.illegal_op, bus.mem_timeout}), 0);
    reset = 1'b0;

    // LW, ready on first MEM cycle: 0,1,2,3,4,0
    accept(4'b0000);
    chk("lw_decode_regwr", int'(bus.reg_write), 0);
    tick();
    chk("lw_exec_state", int'(bus.state), 2);
    chk("lw_exec_alu_src", int'(bus.alu_src), 1);
    chk("lw_exec_alu_op", int'(bus.alu_op), 0);
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    chk("lw_mem_state", int'(bus.state), 3);
    chk("lw_mem_read", int'(bus.mem_read), 1);
    chk("lw_mem_regwr", int'(bus.reg_write), 0);
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    chk("lw_wb_state", int'(bus.state), 4);
    chk("lw_wb_regwr", int'(bus.reg_write), 1);
    chk("lw_wb_memtoreg", int'(bus.mem_to_reg), 1);
    chk("lw_wb_regdst", int'(bus.reg_dst), 0);
    tick();
    chk("lw_done_state", int'(bus.state), 0);
    chk("lw_done_regwr", int'(bus.reg_write), 0);

    // SW with 3 waits: mem_write for exactly 4 MEM cycles
    accept(4'b0001);
    tick();
    chk("sw_exec_memwr", int'(bus.mem_write), 0);
    tick();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 4'd0, 1'b0, (k == 4));
      chk("sw_mem_state", int'(bus.state), 3);
      chk("sw_mem_write", int'(bus.mem_write), 1);
      chk("sw_mem_regwr", int'(bus.reg_write), 0);
      tick();
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    chk("sw_done_state", int'(bus.state), 0);
    chk("sw_done_memwr", int'(bus.mem_write), 0);

    // DP
    accept(4'b0101);
    tick();
    chk("dp_exec_state", int'(bus.state), 2);
    chk("dp_exec_alu_op", int'(bus.alu_op), 2);
    chk("dp_exec_alu_src", int'(bus.alu_src), 0);
    tick();
    chk("dp_wb_state", int'(bus.state), 4);
    chk("dp_wb_regdst", int'(bus.reg_dst), 1);
    chk("dp_wb_memtoreg", int'(bus.mem_to_reg), 0);
    chk("dp_wb_regwr", int'(bus.reg_write), 1);
    tick();
    chk("dp_done_state", int'(bus.state), 0);

    // BEQ zero=1: taken
    accept(4'b1011);
    tick();
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    chk("beq_alu_op", int'(bus.alu_op), 1);
    chk("beq_pc_write", int'(bus.pc_write), 1);
    chk("beq_pc_src", int'(bus.pc_src), 1);
    tick();
    chk("beq_done_state", int'(bus.state), 0);

    // BNE zero=1: not taken
    accept(4'b1100);
    tick();
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    chk("bne_z1_pc_write", int'(bus.pc_write), 0);
    chk("bne_z1_pc_src", int'(bus.pc_src), 0);
    chk("bne_z1_alu_op", int'(bus.alu_op), 1);
    tick();

    // BNE zero=0: taken
    accept(4'b1100);
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    chk("bne_z0_pc_write", int'(bus.pc_write), 1);
    chk("bne_z0_pc_src", int'(bus.pc_src), 1);
    tick();

    // J
    accept(4'b1101);
    tick();
    chk("j_pc_write", int'(bus.pc_write), 1);
    chk("j_pc_src", int'(bus.pc_src), 2);
    tick();
    chk("j_done_state", int'(bus.state), 0);

    // Illegal 1110: ERROR held for 10 cycles despite inputs
    accept(4'b1110);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 4'd0, 1'b1, 1'b1);
      chk("ill_state", int'(bus.state), 5);
      chk("ill_flag", int'(bus.illegal_op), 1);
      chk("ill_fetch_req", int'(bus.fetch_req), 0);
      chk("ill_pc_write", int'(bus.pc_write), 0);
      tick();
    end
    reset = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    chk("ill_rst_fetch_req", int'(bus.fetch_req), 1);
    chk("ill_rst_flag", int'(bus.illegal_op), 0);
    tick();
    reset = 1'b0;
    #1;
    chk("ill_after_state", int'(bus.state), 0);
    chk("ill_after_flag", int'(bus.illegal_op), 0);

    // Illegal 1010 and 1111
    accept(4'b1010);
    tick();
    chk("ill1010_state", int'(bus.state), 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    accept(4'b1111);
    tick();
    chk("ill1111_state", int'(bus.state), 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;

    // Timeout: 15 MEM cycles without ready -> ERROR
    accept(4'b0000);
    tick();
    tick();
    for (int k = 1; k <= 15; k++) begin
      drive(1'b0, 4'd0, 1'b0, 1'b0);
      chk("to_mem_state", int'(bus.state), 3);
      chk("to_mem_read", int'(bus.mem_read), 1);
      chk("to_flag_clear", int'(bus.mem_timeout), 0);
      tick();
    end
    chk("to_err_state", int'(bus.state), 5);
    chk("to_err_flag", int'(bus.mem_timeout), 1);
    chk("to_err_illegal", int'(bus.illegal_op), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("to_rst_flag", int'(bus.mem_timeout), 0);

    // Ready on exactly the 15th MEM cycle -> normal WB
    accept(4'b0000);
    tick();
    tick();
    for (int k = 1; k <= 15; k++) begin
      drive(1'b0, 4'd0, 1'b0, (k == 15));
      chk("edge_mem_state", int'(bus.state), 3);
      tick();
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    chk("edge_wb_state", int'(bus.state), 4);
    chk("edge_flag", int'(bus.mem_timeout), 0);
    chk("edge_wb_regwr", int'(bus.reg_write), 1);
    tick();
    chk("edge_done_state", int'(bus.state), 0);

    // Reset during 2nd MEM cycle of SW
    accept(4'b0001);
    tick();
    tick();
    chk("rm_mem1_state", int'(bus.state), 3);
    tick();
    chk("rm_mem2_state", int'(bus.state), 3);
    chk("rm_mem2_write", int'(bus.mem_write), 1);
    reset = 1'b1;
    #1;
    chk("rm_rst_write", int'(bus.mem_write), 0);
    chk("rm_rst_fetch_req", int'(bus.fetch_req), 1);
    tick();
    reset = 1'b0;
    #1;
    chk("rm_after_state", int'(bus.state), 0);
    chk("rm_after_write", int'(bus.mem_write), 0);
    chk("rm_after_flags", int'({bus.illegal_op, bus.mem_timeout}), 0);

    // Normal operation resumes after reset: SW completes immediately
    accept(4'b0001);
    tick();
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    chk("post_sw_write", int'(bus.mem_write), 1);
    tick();
    chk("post_sw_state", int'(bus.state), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
